// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared multiplier, with a
// per-operation WAIT timeout and registered response.
module mult_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_grant,
  output logic        req1_grant,
  output logic        req0_done,
  output logic        req1_done,
  output logic [31:0] rsp_result,
  output logic        rsp_exception,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        mult_enable,
  output logic [31:0] mult_multiplicand,
  output logic [31:0] mult_multiplier,
  input  logic [31:0] mult_result,
  input  logic        mult_ready,
  input  logic        mult_exception
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_exception_q, rsp_exception_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        sel;
  logic        grant0, grant1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      id_q            <= 1'b0;
      last_q          <= 1'b1;
      cnt_q           <= '0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      rsp_result_q    <= '0;
      rsp_exception_q <= 1'b0;
      rsp_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      id_q            <= id_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      rsp_result_q    <= rsp_result_d;
      rsp_exception_q <= rsp_exception_d;
      rsp_timeout_q   <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    rsp_result_d    = rsp_result_q;
    rsp_exception_d = rsp_exception_q;
    rsp_timeout_d   = rsp_timeout_q;
    sel             = 1'b0;
    grant0          = 1'b0;
    grant1          = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester that was not served last wins.
          sel     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          id_d    = sel;
          op_a_d  = sel ? req1_a : req0_a;
          op_b_d  = sel ? req1_b : req0_b;
          grant0  = ~sel;
          grant1  = sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mult_ready) begin
          rsp_result_d    = mult_result;
          rsp_exception_d = mult_exception;
          rsp_timeout_d   = 1'b0;
          state_d         = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d    = '0;
          rsp_exception_d = 1'b1;
          rsp_timeout_d   = 1'b1;
          state_d         = RESP;
        end
      end
      RESP: begin
        last_d  = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are combinational in IDLE, so they are masked while reset is held.
  assign req0_grant        = grant0 & reset_n;
  assign req1_grant        = grant1 & reset_n;
  assign req0_done         = (state_q == RESP) && !id_q;
  assign req1_done         = (state_q == RESP) && id_q;
  assign busy              = (state_q != IDLE);
  assign mult_enable       = (state_q == ISSUE);
  assign mult_multiplicand = (state_q == IDLE) ? '0 : op_a_q;
  assign mult_multiplier   = (state_q == IDLE) ? '0 : op_b_q;
  assign rsp_result        = rsp_result_q;
  assign rsp_exception     = rsp_exception_q;
  assign rsp_timeout       = rsp_timeout_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: behavioural multiplier with programmable
// latency plus a round-robin/timeout reference model.
module tb_mult_arbiter;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_grant, req1_grant, req0_done, req1_done;
  logic [31:0] rsp_result;
  logic        rsp_exception, rsp_timeout, busy, mult_enable;
  logic [31:0] mult_multiplicand, mult_multiplier;
  logic [31:0] mult_result = '0;
  logic        mult_ready = 1'b0;
  logic        mult_exception = 1'b0;

  int checks = 0;
  int failures = 0;

  mult_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_grant(req0_grant), .req1_grant(req1_grant),
    .req0_done(req0_done), .req1_done(req1_done),
    .rsp_result(rsp_result), .rsp_exception(rsp_exception), .rsp_timeout(rsp_timeout),
    .busy(busy), .mult_enable(mult_enable),
    .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
    .mult_result(mult_result), .mult_ready(mult_ready), .mult_exception(mult_exception)
  );

  always #5 clock = ~clock;

  // Behavioural multiplier: ready pulses on the m_lat-th cycle after the enable
  // cycle; m_lat == 0 means it never answers.
  int          m_lat = 0;
  int          m_cnt = 0;
  bit          m_active = 0;
  logic [31:0] m_res = '0;
  logic        m_exc = 1'b0;

  always @(negedge clock) begin
    if (!reset_n || !busy) begin
      m_active = 0;
      mult_ready = 1'b0;
    end else if (mult_enable) begin
      m_active = 1;
      m_cnt = 0;
      mult_ready = 1'b0;
    end else if (m_active) begin
      m_cnt++;
      if (m_lat != 0 && m_cnt == m_lat) begin
        mult_ready = 1'b1;
        mult_result = m_res;
        mult_exception = m_exc;
        m_active = 0;
      end else begin
        mult_ready = 1'b0;
      end
    end else begin
      mult_ready = 1'b0;
    end
  end

  // Reference model state: who was served last (1 after reset).
  bit last_served = 1'b1;

  function automatic bit exp_winner(input bit v0, input bit v1);
    if (v0 && v1) return ~last_served;
    return v1;
  endfunction

  function automatic int exp_wait(input int lat);
    if (lat >= 1 && lat <= TIMEOUT) return lat;
    return TIMEOUT;
  endfunction

  // Observations filled by run_txn.
  int          obs_gid, obs_did, obs_grants, obs_enables, obs_dones, obs_wait, obs_total;
  bit          obs_hung;
  logic [31:0] obs_a, obs_b, obs_da, obs_db, obs_res;
  logic        obs_exc, obs_to;

  task automatic run_txn(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int lat, input logic [31:0] res, input logic exc,
                         input bit hold);
    obs_gid = -1; obs_did = -1; obs_grants = 0; obs_enables = 0; obs_dones = 0;
    obs_wait = 0; obs_total = -1; obs_hung = 1;
    obs_a = '0; obs_b = '0; obs_da = '0; obs_db = '0; obs_res = '0; obs_exc = 0; obs_to = 0;
    @(negedge clock);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    m_lat = lat; m_res = res; m_exc = exc;
    #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (req0_grant) begin obs_grants++; obs_gid = 0; end
      if (req1_grant) begin obs_grants++; obs_gid = 1; end
      if (mult_enable) begin
        obs_enables++;
        obs_a = mult_multiplicand;
        obs_b = mult_multiplier;
      end
      if (busy && !mult_enable && !req0_done && !req1_done) obs_wait++;
      if (req0_done || req1_done) begin
        obs_did = req1_done ? 1 : 0;
        obs_dones = int'(req0_done) + int'(req1_done);
        obs_res = rsp_result; obs_exc = rsp_exception; obs_to = rsp_timeout;
        obs_da = mult_multiplicand; obs_db = mult_multiplier;
        obs_total = cyc;
        obs_hung = 0;
        return;
      end
      @(negedge clock);
      if (obs_grants > 0 && !hold) begin
        req0_valid = 0; req1_valid = 0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      end
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    last_served = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if ({req0_grant, req1_grant, req0_done, req1_done, mult_enable} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {req0_grant, req1_grant, req0_done, req1_done, mult_enable});
    end
    checks++;
    if ({mult_multiplicand, mult_multiplier} !== 64'h0) begin
      failures++;
      $display("FAIL reset_operands: got %h/%h expected 0/0", mult_multiplicand, mult_multiplier);
    end
    checks++;
    if ({rsp_result, rsp_exception, rsp_timeout} !== 34'h0) begin
      failures++;
      $display("FAIL reset_rsp: got %h %b %b expected 0 0 0", rsp_result, rsp_exception, rsp_timeout);
    end
    @(negedge clock);
    reset_n = 1'b1;
    last_served = 1'b1;
  endtask

  task automatic test_basic();
    run_txn(1, 0, 32'd78, 32'd13, 32'd0, 32'd0, 32, 32'd1014, 1'b0, 0);
    checks++;
    if (obs_hung) begin failures++; $display("FAIL basic_done: got no done expected done"); end
    checks++;
    if (obs_gid !== 0 || obs_grants !== 1) begin
      failures++; $display("FAIL basic_grant: got id %0d x%0d expected id 0 x1", obs_gid, obs_grants);
    end
    checks++;
    if (obs_enables !== 1) begin failures++; $display("FAIL basic_enable: got %0d expected 1", obs_enables); end
    checks++;
    if (obs_a !== 32'd78 || obs_b !== 32'd13) begin
      failures++; $display("FAIL basic_operands: got %0d/%0d expected 78/13", obs_a, obs_b);
    end
    checks++;
    if (obs_da !== 32'd78 || obs_db !== 32'd13) begin
      failures++; $display("FAIL basic_operands_resp: got %0d/%0d expected 78/13", obs_da, obs_db);
    end
    checks++;
    if (obs_did !== 0 || obs_dones !== 1) begin
      failures++; $display("FAIL basic_done_id: got %0d x%0d expected 0 x1", obs_did, obs_dones);
    end
    checks++;
    if ({obs_res, obs_exc, obs_to} !== {32'd1014, 1'b0, 1'b0}) begin
      failures++; $display("FAIL basic_rsp: got %0d %b %b expected 1014 0 0", obs_res, obs_exc, obs_to);
    end
    checks++;
    if (obs_wait !== 32 || obs_total !== 34) begin
      failures++; $display("FAIL basic_latency: got wait %0d total %0d expected 32 34", obs_wait, obs_total);
    end
    last_served = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (rsp_result !== 32'd1014 || busy !== 1'b0 || req0_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: got %0d busy %b done %b expected 1014 0 0", rsp_result, busy, req0_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, b0, a1, b1, pa, pb;
    int seq [4] = '{0, 1, 0, 1};
    bit w;
    int lat;
    logic [63:0] prod;
    do_reset();
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    for (int i = 0; i < 4; i++) begin
      w = exp_winner(1, 1);
      lat = $urandom_range(1, 10);
      pa = w ? a1 : a0;
      pb = w ? b1 : b0;
      prod = 64'(pa) * 64'(pb);
      run_txn(1, 1, a0, b0, a1, b1, lat, prod[31:0], |prod[63:32], 1);
      checks++;
      if (obs_hung || obs_gid !== seq[i] || obs_gid !== int'(w)) begin
        failures++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, obs_gid, seq[i]);
      end
      checks++;
      if (obs_did !== seq[i]) begin
        failures++; $display("FAIL rr_done[%0d]: got %0d expected %0d", i, obs_did, seq[i]);
      end
      checks++;
      if (obs_res !== prod[31:0] || obs_exc !== |prod[63:32] || obs_a !== pa) begin
        failures++; $display("FAIL rr_rsp[%0d]: got %h %b op %h expected %h %b op %h",
                             i, obs_res, obs_exc, obs_a, prod[31:0], |prod[63:32], pa);
      end
      last_served = w;
    end
    @(negedge clock);
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_overflow();
    bit w;
    w = exp_winner(0, 1);
    run_txn(0, 1, 32'd0, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 5, 32'h00000001, 1'b1, 0);
    checks++;
    if (obs_hung || obs_did !== int'(w)) begin
      failures++; $display("FAIL ovf_done: got %0d expected %0d", obs_did, w);
    end
    checks++;
    if ({obs_res, obs_exc, obs_to} !== {32'h1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL ovf_rsp: got %h %b %b expected 00000001 1 0", obs_res, obs_exc, obs_to);
    end
    last_served = w;
  endtask

  task automatic test_timeout();
    run_txn(1, 0, 32'd5, 32'd6, 32'd0, 32'd0, 0, 32'd30, 1'b0, 0);
    checks++;
    if (obs_hung || obs_did !== 0) begin failures++; $display("FAIL to_done: got %0d expected 0", obs_did); end
    checks++;
    if ({obs_res, obs_exc, obs_to} !== {32'h0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL to_rsp: got %h %b %b expected 0 1 1", obs_res, obs_exc, obs_to);
    end
    checks++;
    if (obs_wait !== TIMEOUT || obs_total !== TIMEOUT + 2) begin
      failures++; $display("FAIL to_latency: got wait %0d total %0d expected %0d %0d",
                           obs_wait, obs_total, TIMEOUT, TIMEOUT + 2);
    end
    last_served = 1'b0;
  endtask

  task automatic test_ready_on_timeout();
    bit w;
    w = exp_winner(1, 1);
    run_txn(1, 1, 32'd3, 32'd4, 32'd7, 32'd9, TIMEOUT, 32'hDEADBEEF, 1'b0, 0);
    checks++;
    if (obs_hung || obs_gid !== int'(w)) begin
      failures++; $display("FAIL rto_grant: got %0d expected %0d", obs_gid, w);
    end
    checks++;
    if ({obs_res, obs_exc, obs_to} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      failures++; $display("FAIL rto_rsp: got %h %b %b expected deadbeef 0 0", obs_res, obs_exc, obs_to);
    end
    checks++;
    if (obs_wait !== TIMEOUT) begin
      failures++; $display("FAIL rto_wait: got %0d expected %0d", obs_wait, TIMEOUT);
    end
    last_served = w;
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    @(negedge clock);
    req0_valid = 1; req0_a = 32'd11; req0_b = 32'd12; m_lat = 0;
    @(negedge clock);
    req0_valid = 0;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, req0_grant, req1_grant, req0_done, req1_done, mult_enable} !== 6'b0 ||
        {mult_multiplicand, mult_multiplier, rsp_result, rsp_exception, rsp_timeout} !== 98'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got busy %b en %b ops %h/%h rsp %h expected all 0",
               busy, mult_enable, mult_multiplicand, mult_multiplier, rsp_result);
    end
    for (int i = 0; i < 80; i++) begin
      if (i == 3) reset_n = 1'b1;
      #1;
      if (req0_done || req1_done) saw_done = 1;
      @(negedge clock);
    end
    last_served = 1'b1;
    checks++;
    if (saw_done) begin failures++; $display("FAIL midreset_nodone: got done expected none"); end
    run_txn(0, 1, 32'd0, 32'd0, 32'd21, 32'd2, 7, 32'd42, 1'b0, 0);
    checks++;
    if (obs_hung || obs_gid !== 1 || obs_did !== 1) begin
      failures++; $display("FAIL midreset_next: got grant %0d done %0d expected 1 1", obs_gid, obs_did);
    end
    checks++;
    if ({obs_res, obs_exc, obs_to} !== {32'd42, 1'b0, 1'b0} || obs_wait !== 7) begin
      failures++; $display("FAIL midreset_rsp: got %0d %b %b wait %0d expected 42 0 0 7",
                           obs_res, obs_exc, obs_to, obs_wait);
    end
    last_served = 1'b1;
  endtask

  task automatic test_random();
    bit v0, v1, w;
    logic [31:0] a0, b0, a1, b1, pa, pb, eres;
    logic [63:0] prod;
    logic eexc, eto;
    int lat;
    for (int i = 0; i < 40; i++) begin
      do begin v0 = 1'($urandom); v1 = 1'($urandom); end while (!v0 && !v1);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 70);
      w = exp_winner(v0, v1);
      pa = w ? a1 : a0;
      pb = w ? b1 : b0;
      prod = 64'(pa) * 64'(pb);
      run_txn(v0, v1, a0, b0, a1, b1, lat, prod[31:0], |prod[63:32], 0);
      if (lat >= 1 && lat <= TIMEOUT) begin
        eres = prod[31:0]; eexc = |prod[63:32]; eto = 1'b0;
      end else begin
        eres = '0; eexc = 1'b1; eto = 1'b1;
      end
      checks++;
      if (obs_hung || obs_gid !== int'(w) || obs_did !== int'(w) || obs_grants !== 1) begin
        failures++; $display("FAIL rnd_id[%0d]: got grant %0d done %0d x%0d expected %0d",
                             i, obs_gid, obs_did, obs_grants, w);
      end
      checks++;
      if (obs_a !== pa || obs_b !== pb || obs_da !== pa || obs_db !== pb) begin
        failures++; $display("FAIL rnd_ops[%0d]: got %h/%h expected %h/%h", i, obs_a, obs_b, pa, pb);
      end
      checks++;
      if ({obs_res, obs_exc, obs_to} !== {eres, eexc, eto} || obs_wait !== exp_wait(lat)) begin
        failures++; $display("FAIL rnd_rsp[%0d]: got %h %b %b wait %0d expected %h %b %b wait %0d",
                             i, obs_res, obs_exc, obs_to, obs_wait, eres, eexc, eto, exp_wait(lat));
      end
      last_served = w;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, maximum WAIT cycles before an operation is aborted; legal range 2..255.
REQ-002 clock  input  1  system clock; all state changes on posedge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  32 each  multiplicand/multiplier from requester N.
REQ-006 req0_grant, req1_grant  output  1 each  one-cycle pulse: operation of requester N accepted.
REQ-007 req0_done, req1_done  output  1 each  one-cycle pulse: rsp_* valid for requester N.
REQ-008 rsp_result  output  32  product returned to the requester.
REQ-009 rsp_exception  output  1  overflow or abort flag for the returned product.
REQ-010 rsp_timeout  output  1  operation aborted by timeout.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mult_enable  output  1  start pulse to the shared multiplier.
REQ-013 mult_multiplicand, mult_multiplier  output  32 each  operands to the multiplier.
REQ-014 mult_result  input  32; mult_ready  input  1; mult_exception  input  1  multiplier outputs.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; exactly one active per cycle.
REQ-016 IDLE: if any reqN_valid, select one, latch its operands and id, pulse reqN_grant that cycle, go ISSUE; else stay.
REQ-017 Arbitration round-robin on a 1-bit last-served pointer: single valid wins; both valid -> requester not last served wins.
REQ-018 Pointer updates to the served id on leaving RESP only.
REQ-019 ISSUE: mult_enable=1 for exactly this cycle, clear timeout counter, go WAIT.
REQ-020 mult_multiplicand/mult_multiplier driven from latched operands, stable from ISSUE through RESP; 0 in IDLE.
REQ-021 WAIT: counter increments each cycle; mult_ready=1 -> capture mult_result and mult_exception, go RESP.
REQ-022 WAIT: counter reaching TIMEOUT-1 with mult_ready=0 -> rsp_result=0, rsp_exception=1, rsp_timeout=1, go RESP.
REQ-023 mult_ready and timeout in the same cycle -> ready wins, rsp_timeout=0.
REQ-024 mult_ready outside WAIT is ignored.
REQ-025 RESP: reqN_done=1 for the latched id only, for exactly one cycle, then IDLE.
REQ-026 rsp_result/rsp_exception/rsp_timeout hold their value until the next RESP.
REQ-027 reqN_valid while busy is ignored; a request dropped before grant is never granted.
REQ-028 Requester holds valid and operands until its grant; arbiter never reads them after the grant cycle.
REQ-029 No arithmetic in the block; rsp_result is passed through unchanged.
REQ-030 Minimum latency valid->done is 3 cycles plus multiplier cycles in WAIT.

Reset
REQ-031 reset_n low, any state: state=IDLE, all outputs 0, counter 0, pointer=1 (requester 0 wins first tie).
REQ-032 Reset mid-operation discards the in-flight operation; no done pulse is generated for it.
REQ-033 First request after reset_n release is accepted on the first clock edge at which valid is sampled.

Verification
REQ-034 req0 a=78 b=13; model ready after 32 cycles with 1014 -> grant0 1 pulse, mult_enable 1 pulse, done0 with rsp_result=1014, exception 0, timeout 0.
REQ-035 Both valid after reset, held high -> grants 0,1,0,1 in order; each done matches its grant id.
REQ-036 a=b=32'h7FFFFFFF; model returns 32'h00000001, exception=1 -> rsp_result=32'h00000001, rsp_exception=1.
REQ-037 Model never ready, TIMEOUT=64 -> done after 64 WAIT cycles, rsp_result=0, exception=1, timeout=1.
REQ-038 mult_ready on the timeout cycle -> rsp_timeout=0, result captured.
REQ-039 reset_n low during WAIT -> no done, all outputs 0; the next req1 request completes normally.
